// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by the IF and MEM pipeline stages.
// One access at a time, fixed wait states, one-cycle ack, combinational stall request.
module mem_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        stallreq_o
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT  = CW'(WAIT_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_owner_mem;
    logic [CW-1:0] r_wait_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic          r_ram_we;
    logic [3:0]    r_ram_sel;
    logic [31:0]   r_ram_addr;
    logic [31:0]   r_ram_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_mem_rdata;
    logic          w_force_if;
    logic          w_grant;
    logic          w_grant_mem;

    assign w_force_if = (STARVE_LIMIT != 0) && (r_starve_cnt == STARVE_MAX);

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_mem  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mem_req_i && !(if_req_i && w_force_if)) begin
                    w_grant     = 1'b1;
                    w_grant_mem = 1'b1;
                end else if (if_req_i) begin
                    w_grant = 1'b1;
                end
                if (w_grant) w_next_state = S_BUSY;
            end
            S_BUSY: begin
                if (r_wait_cnt == '0) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_mem  <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_ram_we     <= 1'b0;
            r_ram_sel    <= 4'h0;
            r_ram_addr   <= 32'h0;
            r_ram_wdata  <= 32'h0;
            r_if_rdata   <= 32'h0;
            r_mem_rdata  <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner_mem <= w_grant_mem;
                r_wait_cnt  <= WAIT_INIT;
                if (w_grant_mem) begin
                    r_ram_we    <= mem_we_i;
                    r_ram_sel   <= mem_sel_i;
                    r_ram_addr  <= mem_addr_i;
                    r_ram_wdata <= mem_wdata_i;
                    // Count MEM wins only while IF is actually waiting.
                    if (!if_req_i) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != STARVE_MAX) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end else begin
                    r_ram_we     <= 1'b0;
                    r_ram_sel    <= 4'hF;
                    r_ram_addr   <= if_addr_i;
                    r_ram_wdata  <= 32'h0;
                    r_starve_cnt <= '0;
                end
            end
            if (r_state == S_BUSY) begin
                if (r_wait_cnt == '0) begin
                    if (!r_ram_we) begin
                        if (r_owner_mem) r_mem_rdata <= ram_rdata_i;
                        else             r_if_rdata  <= ram_rdata_i;
                    end
                end else begin
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                end
            end
        end
    end

    // Requesters hold req until their ack pulse; ack lasts one cycle and data is valid with it.
    assign ram_ce_o    = (r_state == S_BUSY);
    assign ram_we_o    = (r_state == S_BUSY) && r_ram_we;
    assign ram_sel_o   = r_ram_sel;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;
    assign if_ack_o    = (r_state == S_DONE) && !r_owner_mem;
    assign mem_ack_o   = (r_state == S_DONE) && r_owner_mem;
    assign if_rdata_o  = r_if_rdata;
    assign mem_rdata_o = r_mem_rdata;
    assign stallreq_o  = (if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o);

endmodule
